rs_syndrome: RTL and testbench

- Front end of the RS(7,k) decoder over GF(8), primitive polynomial x^3+x+1, alpha = 3'd2.
- Accepts one received codeword as a symbol stream, highest-degree coefficient first.
- Computes syndromes S_j = r(alpha^j), j = 1..NSYM, by Horner accumulation.
- Presents the syndromes on a valid/ready output register that feeds the key-equation solver.

---
 rtl/rs_gf8_pkg.sv | 29 ++
 rtl/gf8mul.sv | 29 ++
 rtl/rs_syn_cell.sv | 52 +++++
 rtl/rs_syndrome.sv | 136 +++++++++++++
 tb/tb_rs_syndrome.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_gf8_pkg.sv
// ----------------------------------------------------------------------------
// rs_gf8_pkg
// Shared GF(8) definitions for the RS(7,k) decoder front end.
// Field: primitive polynomial x^3 + x + 1, primitive element alpha = 3'd2.
// Contents:
//   gf8_sym_t       3-bit field symbol
//   RS_N            codeword length in symbols
//   GF8_POLY        low bits of the reduction polynomial (x^3 folds to x + 1)
//   GF8_ALPHA_POW   alpha^i for i = 0..6
//   gf8_xtime()     multiply a symbol by alpha
// ----------------------------------------------------------------------------
package rs_gf8_pkg;

    typedef logic [2:0] gf8_sym_t;

    localparam int unsigned RS_N = 7;

    localparam gf8_sym_t GF8_POLY = 3'b011;

    localparam gf8_sym_t GF8_ALPHA_POW [0:6] = '{
        3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5
    };

    // Multiply by alpha: shift left, fold the x^3 term back in as x + 1.
    function automatic gf8_sym_t gf8_xtime(input gf8_sym_t a);
        return {a[1:0], 1'b0} ^ (a[2] ? GF8_POLY : 3'b000);
    endfunction

endpackage

// File: rtl/gf8mul.sv
// ----------------------------------------------------------------------------
// gf8mul
// Combinational GF(8) multiplier, field x^3 + x + 1.
// When one operand is a constant, synthesis reduces this to a few XORs.
// Ports:
//   i_a  [2:0]  first operand
//   i_b  [2:0]  second operand
//   o_p  [2:0]  product i_a * i_b
// ----------------------------------------------------------------------------
module gf8mul
    import rs_gf8_pkg::*;
(
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic [2:0] o_p
);

    gf8_sym_t w_a1;
    gf8_sym_t w_a2;

    // i_a * alpha and i_a * alpha^2, selected by the bits of i_b.
    assign w_a1 = gf8_xtime(i_a);
    assign w_a2 = gf8_xtime(w_a1);

    assign o_p = (i_b[0] ? i_a  : 3'b000)
               ^ (i_b[1] ? w_a1 : 3'b000)
               ^ (i_b[2] ? w_a2 : 3'b000);

endmodule

// File: rtl/rs_syn_cell.sv
// ----------------------------------------------------------------------------
// rs_syn_cell
// One Horner accumulator for syndrome S_J = r(alpha^J).
// Each accepted symbol updates acc <= (first ? 0 : acc * alpha^J) ^ sym.
// o_next is that update value; the parent captures it as the finished
// syndrome on the last symbol of a word.
// Parameters:
//   J        syndrome index (1..6)
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   i_en     a symbol transfers this cycle
//   i_first  the transferring symbol starts a new word
//   i_sym    [2:0] received symbol
//   o_next   [2:0] accumulator next value (combinational)
// ----------------------------------------------------------------------------
module rs_syn_cell
    import rs_gf8_pkg::*;
#(
    parameter int unsigned J = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_first,
    input  logic [2:0] i_sym,
    output logic [2:0] o_next
);

    localparam gf8_sym_t ALPHA_J = GF8_ALPHA_POW[J % RS_N];

    gf8_sym_t r_acc;
    gf8_sym_t w_mul;

    gf8mul u_mul (
        .i_a (r_acc),
        .i_b (ALPHA_J),
        .o_p (w_mul)
    );

    // A new word discards whatever is left in the accumulator.
    assign o_next = (i_first ? 3'b000 : w_mul) ^ i_sym;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 3'b000;
        end else if (i_en) begin
            r_acc <= o_next;
        end
    end

endmodule

// File: rtl/rs_syndrome.sv
// ----------------------------------------------------------------------------
// rs_syndrome
// Syndrome front end of the RS(7,k) decoder over GF(8).
// Takes a codeword as a symbol stream, highest-degree coefficient first, and
// computes S_j = r(alpha^j) for j = 1..NSYM with one Horner cell per syndrome.
// The finished syndromes sit in a valid/ready output register that feeds the
// key-equation solver.
//
// Optional feature (compile-time macro RS_SYN_ERRCNT_EN):
//   defined   -> err_cnt counts words with nonzero syndromes, saturating,
//                cleared only by reset
//   undefined -> no counter; err_cnt is tied to zero
//
// Parameters:
//   N      codeword length (only 7 is supported for GF(8))
//   NSYM   number of syndromes, 1..6
//   CNT_W  width of err_cnt
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_sym is valid
//   in_ready   a symbol can be accepted this cycle
//   in_sym     [2:0] received symbol
//   in_sop     first symbol of a codeword (resynchronises framing)
//   syn_valid  syndrome register is full
//   syn_ready  downstream accepts the syndromes
//   syn_data   [3*NSYM-1:0] packed syndromes, S1 in [2:0]
//   syn_err    any syndrome nonzero, only while syn_valid
//   err_cnt    [CNT_W-1:0] count of words with nonzero syndromes
// ----------------------------------------------------------------------------
module rs_syndrome
    import rs_gf8_pkg::*;
#(
    parameter int unsigned N     = 7,
    parameter int unsigned NSYM  = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sym,
    input  logic                 in_sop,
    output logic                 syn_valid,
    input  logic                 syn_ready,
    output logic [3*NSYM-1:0]    syn_data,
    output logic                 syn_err,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int unsigned SYN_W    = 3 * NSYM;
    localparam logic [2:0]  LAST_IDX = 3'(N - 1);

    logic [2:0]       r_cnt;
    logic             r_syn_valid;
    logic [SYN_W-1:0] r_syn_data;
    logic             r_syn_err;

    logic [2:0]       w_eff_cnt;
    logic             w_first;
    logic             w_last;
    logic             w_xfer;
    logic             w_load;
    logic [SYN_W-1:0] w_syn_next;

    // in_sop restarts framing; on an idle counter it changes nothing.
    assign w_eff_cnt = in_sop ? 3'd0 : r_cnt;
    assign w_first   = (w_eff_cnt == 3'd0);
    assign w_last    = (w_eff_cnt == LAST_IDX);

    // Only the closing symbol of a word needs room in the output register,
    // so every other symbol keeps flowing under backpressure.
    assign in_ready = !(w_last && r_syn_valid && !syn_ready);
    assign w_xfer   = in_valid && in_ready;
    assign w_load   = w_xfer && w_last;

    for (genvar gi = 0; gi < NSYM; gi++) begin : g_cell
        rs_syn_cell #(
            .J (gi + 1)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_xfer),
            .i_first (w_first),
            .i_sym   (gf8_sym_t'(in_sym)),
            .o_next  (w_syn_next[3*gi +: 3])
        );
    end

    // Symbol position within the current word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 3'd0;
        end else if (w_xfer) begin
            r_cnt <= w_last ? 3'd0 : w_eff_cnt + 3'd1;
        end
    end

    // Output register. A load in the same cycle as a handshake takes priority,
    // which keeps syn_valid high for back-to-back words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syn_valid <= 1'b0;
            r_syn_data  <= '0;
            r_syn_err   <= 1'b0;
        end else if (w_load) begin
            r_syn_valid <= 1'b1;
            r_syn_data  <= w_syn_next;
            r_syn_err   <= |w_syn_next;
        end else if (r_syn_valid && syn_ready) begin
            r_syn_valid <= 1'b0;
            r_syn_err   <= 1'b0;
        end
    end

    assign syn_valid = r_syn_valid;
    assign syn_data  = r_syn_data;
    assign syn_err   = r_syn_err;

`ifdef RS_SYN_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_load && (|w_syn_next) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rs_syndrome.sv
// ----------------------------------------------------------------------------
// tb_rs_syndrome
// Self-checking bench for rs_syndrome. A reference model evaluates each
// received polynomial at alpha^j using log/antilog arithmetic over GF(8) and
// tracks framing, the output queue and the error count independently.
// ----------------------------------------------------------------------------
module tb_rs_syndrome;

    localparam int unsigned NSYM  = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SYN_W = 3 * NSYM;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_sop    = 1'b0;
    logic [2:0]       in_sym    = 3'd0;
    logic             syn_ready = 1'b1;
    logic             in_ready;
    logic             syn_valid;
    logic             syn_err;
    logic [SYN_W-1:0] syn_data;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    bit rand_rdy = 1'b0;

    // Reference model state
    logic [2:0]       cur_q [$];
    logic [SYN_W-1:0] exp_q [$];
    int unsigned      exp_errs = 0;
    bit               mon_v;
    bit               mon_rdy;
    int               mon_eff;
    logic [SYN_W-1:0] mon_s;

    logic [2:0] gen_cw [7] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd1, 3'd2, 3'd3};
    logic [2:0] e6_w   [7] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [2:0] e0_w   [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3};

    always #5 clk = ~clk;

    rs_syndrome #(
        .N     (7),
        .NSYM  (NSYM),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_sop    (in_sop),
        .syn_valid (syn_valid),
        .syn_ready (syn_ready),
        .syn_data  (syn_data),
        .syn_err   (syn_err),
        .err_cnt   (err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // alpha^i by repeated doubling modulo x^3 + x + 1 (0b1011)
    function automatic int gf_exp(input int i);
        int v;
        v = 1;
        for (int k = 0; k < (i % 7); k++) begin
            v = v * 2;
            if (v >= 8) v = v ^ 11;
        end
        return v;
    endfunction

    function automatic int gf_log(input int a);
        for (int i = 0; i < 7; i++) begin
            if (gf_exp(i) == a) return i;
        end
        return 0;
    endfunction

    function automatic int gf_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gf_exp(gf_log(a) + gf_log(b));
    endfunction

    // S_j = sum_k r_k * alpha^(deg_k * j); w[0] holds the degree-6 coefficient.
    function automatic logic [SYN_W-1:0] model_syn(input logic [2:0] w [$]);
        logic [SYN_W-1:0] res;
        int s;
        res = '0;
        for (int j = 1; j <= NSYM; j++) begin
            s = 0;
            for (int k = 0; k < 7; k++) begin
                s = s ^ gf_mul(int'(w[k]), gf_exp((6 - k) * j));
            end
            res[3*j-3 +: 3] = 3'(s);
        end
        return res;
    endfunction

    // Monitor: compare outputs with the model, then apply the handshakes that
    // the next rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_q.delete();
            exp_q.delete();
            exp_errs = 0;
        end else begin
            mon_v = (exp_q.size() != 0);
            check_eq("syn_valid", 32'(syn_valid), 32'(mon_v));
            if (mon_v) begin
                check_eq("syn_data", 32'(syn_data), 32'(exp_q[0]));
                check_eq("syn_err", 32'(syn_err), 32'(exp_q[0] != '0));
            end else begin
                check_eq("syn_err_idle", 32'(syn_err), 32'd0);
            end
`ifdef RS_SYN_ERRCNT_EN
            check_eq("err_cnt", 32'(err_cnt), 32'(exp_errs));
`else
            check_eq("err_cnt", 32'(err_cnt), 32'd0);
`endif
            mon_eff = in_sop ? 0 : cur_q.size();
            mon_rdy = !((mon_eff == 6) && mon_v && !syn_ready);
            check_eq("in_ready", 32'(in_ready), 32'(mon_rdy));

            if (mon_v && syn_ready) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                if (in_sop) cur_q.delete();
                cur_q.push_back(in_sym);
                if (cur_q.size() == 7) begin
                    mon_s = model_syn(cur_q);
                    exp_q.push_back(mon_s);
                    if (mon_s != '0 && exp_errs < (2 ** CNT_W) - 1) exp_errs++;
                    cur_q.delete();
                end
            end
        end
    end

    // All driver activity happens 1 time unit after a rising edge.
    task automatic send_sym(input logic [2:0] s, input logic sop);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sym   = s;
        in_sop   = sop;
        if (rand_rdy) syn_ready = 1'($urandom_range(0, 1));
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check_eq("send_timeout", 32'(in_ready), 32'd1);
                break;
            end
            @(posedge clk);
            #1;
            if (rand_rdy) syn_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_word(input logic [2:0] w [7], input logic sop);
        for (int k = 0; k < 7; k++) send_sym(w[k], sop && (k == 0));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (rand_rdy) syn_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_syn_valid"}, 32'(syn_valid), 32'd0);
        check_eq({tag, "_syn_data"}, 32'(syn_data), 32'd0);
        check_eq({tag, "_syn_err"}, 32'(syn_err), 32'd0);
        check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit sop;

        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Valid codeword: zero syndromes, visible one cycle after the 7th symbol
        send_word(gen_cw, 1'b1);
        check_eq("cw_valid", 32'(syn_valid), 32'd1);
        check_eq("cw_data", 32'(syn_data), 32'h000);
        check_eq("cw_err", 32'(syn_err), 32'd0);
        idle(2);

        // Error at degree 6: S1..S4 = 5,7,6,3
        send_word(e6_w, 1'b1);
        check_eq("e6_valid", 32'(syn_valid), 32'd1);
        check_eq("e6_data", 32'(syn_data), 32'h7BD);
        check_eq("e6_err", 32'(syn_err), 32'd1);
        idle(2);

        // Error at degree 0, framed by the counter alone: S1..S4 = 3,3,3,3
        send_word(e0_w, 1'b0);
        check_eq("e0_valid", 32'(syn_valid), 32'd1);
        check_eq("e0_data", 32'(syn_data), 32'h6DB);
        check_eq("e0_err", 32'(syn_err), 32'd1);
`ifdef RS_SYN_ERRCNT_EN
        check_eq("e0_err_cnt", 32'(err_cnt), 32'd2);
`else
        check_eq("e0_err_cnt", 32'(err_cnt), 32'd0);
`endif
        idle(2);

        // Backpressure: second word stalls only on its last symbol
        syn_ready = 1'b0;
        send_word(e0_w, 1'b1);
        check_eq("bp_first_valid", 32'(syn_valid), 32'd1);
        for (int k = 0; k < 6; k++) send_sym(gen_cw[k], k == 0);
        in_valid = 1'b1;
        in_sym   = gen_cw[6];
        in_sop   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_hold_data", 32'(syn_data), 32'h6DB);
            check_eq("bp_hold_err", 32'(syn_err), 32'd1);
            @(posedge clk);
            #1;
        end
        syn_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp_second_valid", 32'(syn_valid), 32'd1);
        check_eq("bp_second_data", 32'(syn_data), 32'h000);
        check_eq("bp_second_err", 32'(syn_err), 32'd0);
        idle(2);

        // Resync: partial word discarded by in_sop
        send_sym(3'd5, 1'b0);
        send_sym(3'd1, 1'b0);
        send_sym(3'd6, 1'b0);
        send_word(gen_cw, 1'b1);
        check_eq("resync_valid", 32'(syn_valid), 32'd1);
        check_eq("resync_data", 32'(syn_data), 32'h000);
        idle(2);

        // Reset mid-word; the following word has no sop and relies on the
        // counter being cleared
        send_sym(3'd7, 1'b1);
        send_sym(3'd2, 1'b0);
        send_sym(3'd4, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send_word(e6_w, 1'b0);
        check_eq("post_rst_data", 32'(syn_data), 32'h7BD);
        idle(2);

        // Reset while the output register is full and stalled
        syn_ready = 1'b0;
        send_word(e0_w, 1'b1);
        check_eq("rst_full_valid", 32'(syn_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_full");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        syn_ready = 1'b1;
        send_word(e6_w, 1'b0);
        check_eq("post_rst2_valid", 32'(syn_valid), 32'd1);
        check_eq("post_rst2_data", 32'(syn_data), 32'h7BD);
        idle(2);

        // Randomised traffic with random backpressure, partial words and sop
        rand_rdy = 1'b1;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_word(gen_cw, 1'b1);
            end else begin
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 7;
                sop = 1'($urandom_range(0, 1));
                for (int k = 0; k < len; k++) begin
                    send_sym(3'($urandom_range(0, 7)), sop && (k == 0));
                end
            end
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_rdy  = 1'b0;
        syn_ready = 1'b1;
        idle(3);
        check_eq("drain_valid", 32'(syn_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
